// File: rtl/riscv_pkg.sv
// Shared pipeline-control types: sequencer states and the load-use hazard test.
package riscv_pkg;

    typedef enum logic [1:0] {
        CTRL_RUN      = 2'd0,
        CTRL_MEM_WAIT = 2'd1,
        CTRL_HALT_ERR = 2'd2
    } ctrl_state_t;

    localparam int REG_ADDR_W = 5;

    // x0 never carries a real value, so a load targeting it cannot create a hazard.
    function automatic logic is_load_use(
        input logic                  ex_mem_read,
        input logic [REG_ADDR_W-1:0] ex_rd,
        input logic [REG_ADDR_W-1:0] id_rs1,
        input logic                  id_rs1_used,
        input logic [REG_ADDR_W-1:0] id_rs2,
        input logic                  id_rs2_used
    );
        return ex_mem_read && (ex_rd != '0) &&
               ((id_rs1_used && (id_rs1 == ex_rd)) || (id_rs2_used && (id_rs2 == ex_rd)));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_reg <= '0;
        end else if (inc_i && (cnt_reg != '1)) begin
            cnt_reg <= cnt_reg + W'(1);
        end
    end

    assign cnt_o = cnt_reg;

endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: hazard resolution, memory-wait
// freeze with timeout watchdog, and stall/flush performance counters.
module pipe_ctrl
    import riscv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_W          = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       id_rs1_addr_i,
    input  logic [4:0]       id_rs2_addr_i,
    input  logic             id_rs1_used_i,
    input  logic             id_rs2_used_i,
    input  logic [4:0]       ex_rd_addr_i,
    input  logic             ex_mem_read_i,
    input  logic             ex_redirect_i,
    input  logic             mem_active_i,
    input  logic             dmem_ready_i,
    output logic             stall_if_o,
    output logic             stall_id_o,
    output logic             stall_ex_o,
    output logic             stall_mem_o,
    output logic             flush_id_o,
    output logic             flush_ex_o,
    output logic             wb_bubble_o,
    output logic             err_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

    ctrl_state_t     state_reg, state_next;
    logic [TO_W-1:0] tcnt_reg, tcnt_next;
    logic            err_reg;

    logic mem_busy;
    logic load_use;
    logic freeze;
    logic eval_hazard;
    logic redirect_fire;
    logic load_use_fire;

    assign mem_busy = mem_active_i & ~dmem_ready_i;
    assign load_use = is_load_use(ex_mem_read_i, ex_rd_addr_i,
                                  id_rs1_addr_i, id_rs1_used_i,
                                  id_rs2_addr_i, id_rs2_used_i);

    // freeze: whole pipe held; eval_hazard: normal redirect/load-use resolution applies.
    always_comb begin
        state_next  = state_reg;
        tcnt_next   = tcnt_reg;
        freeze      = 1'b0;
        eval_hazard = 1'b0;
        if (rst_i) begin
            state_next = CTRL_RUN;
            tcnt_next  = '0;
        end else begin
            case (state_reg)
                CTRL_RUN: begin
                    if (mem_busy) begin
                        freeze     = 1'b1;
                        state_next = CTRL_MEM_WAIT;
                        tcnt_next  = TO_W'(1);
                    end else begin
                        eval_hazard = 1'b1;
                    end
                end
                CTRL_MEM_WAIT: begin
                    if (!dmem_ready_i) begin
                        freeze = 1'b1;
                        if (tcnt_reg == TO_LIMIT) begin
                            state_next = CTRL_HALT_ERR;
                            tcnt_next  = '0;
                        end else begin
                            tcnt_next = tcnt_reg + TO_W'(1);
                        end
                    end else begin
                        // Release cycle resolves hazards directly, no extra bubble.
                        eval_hazard = 1'b1;
                        state_next  = CTRL_RUN;
                        tcnt_next   = '0;
                    end
                end
                CTRL_HALT_ERR: begin
                    freeze = 1'b1;
                end
                default: begin
                    freeze     = 1'b1;
                    state_next = CTRL_RUN;
                    tcnt_next  = '0;
                end
            endcase
        end
    end

    assign redirect_fire = eval_hazard & ex_redirect_i;
    assign load_use_fire = eval_hazard & ~ex_redirect_i & load_use;

    assign stall_if_o  = freeze | load_use_fire;
    assign stall_id_o  = freeze | load_use_fire;
    assign stall_ex_o  = freeze;
    assign stall_mem_o = freeze;
    assign flush_id_o  = rst_i | redirect_fire;
    assign flush_ex_o  = rst_i | redirect_fire | load_use_fire;
    assign wb_bubble_o = rst_i | freeze;
    assign err_o       = err_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= CTRL_RUN;
            tcnt_reg  <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            tcnt_reg  <= tcnt_next;
            err_reg   <= (state_next == CTRL_HALT_ERR);
        end
    end

    logic [1:0]       cnt_inc;
    logic [CNT_W-1:0] cnt_val [2];

    assign cnt_inc[0] = stall_if_o;
    assign cnt_inc[1] = redirect_fire;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_perf_cnt
            sat_counter #(
                .W(CNT_W)
            ) u_cnt (
                .clk_i(clk_i),
                .rst_i(rst_i),
                .inc_i(cnt_inc[gi]),
                .cnt_o(cnt_val[gi])
            );
        end
    endgenerate

    assign stall_cnt_o = cnt_val[0];
    assign flush_cnt_o = cnt_val[1];

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed checks of pipe_ctrl hazard, memory-wait, timeout and counter behaviour.
module tb_pipe_ctrl;

    localparam int TO    = 4;
    localparam int CNT_W = 4;

    // Control vector: {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, wb_bubble}
    localparam logic [6:0] C_NONE = 7'b0000_000;
    localparam logic [6:0] C_RST  = 7'b0000_111;
    localparam logic [6:0] C_FRZ  = 7'b1111_001;
    localparam logic [6:0] C_RED  = 7'b0000_110;
    localparam logic [6:0] C_LU   = 7'b1100_010;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       id_rs1_addr, id_rs2_addr, ex_rd_addr;
    logic             id_rs1_used, id_rs2_used;
    logic             ex_mem_read, ex_redirect, mem_active, dmem_ready;
    logic             stall_if, stall_id, stall_ex, stall_mem;
    logic             flush_id, flush_ex, wb_bubble, err;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic [6:0]       ctl;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(
        .TIMEOUT_CYCLES(TO),
        .CNT_W(CNT_W)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .id_rs1_addr_i(id_rs1_addr),
        .id_rs2_addr_i(id_rs2_addr),
        .id_rs1_used_i(id_rs1_used),
        .id_rs2_used_i(id_rs2_used),
        .ex_rd_addr_i(ex_rd_addr),
        .ex_mem_read_i(ex_mem_read),
        .ex_redirect_i(ex_redirect),
        .mem_active_i(mem_active),
        .dmem_ready_i(dmem_ready),
        .stall_if_o(stall_if),
        .stall_id_o(stall_id),
        .stall_ex_o(stall_ex),
        .stall_mem_o(stall_mem),
        .flush_id_o(flush_id),
        .flush_ex_o(flush_ex),
        .wb_bubble_o(wb_bubble),
        .err_o(err),
        .stall_cnt_o(stall_cnt),
        .flush_cnt_o(flush_cnt)
    );

    assign ctl = {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, wb_bubble};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = %0h", tag, got);
        end
    endtask

    task automatic idle();
        rst = 1'b0;
        id_rs1_addr = '0; id_rs2_addr = '0; ex_rd_addr = '0;
        id_rs1_used = 1'b0; id_rs2_used = 1'b0;
        ex_mem_read = 1'b0; ex_redirect = 1'b0;
        mem_active = 1'b0; dmem_ready = 1'b0;
    endtask

    // Check control outputs mid-cycle, then advance past the next rising edge.
    task automatic cyc(input string tag, input logic [6:0] exp);
        @(negedge clk);
        check(tag, 32'(ctl), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        idle();
        rst = 1'b1;
        cyc(tag, C_RST);
        rst = 1'b0;
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_scnt"}, 32'(stall_cnt), 32'd0);
        check({tag, "_fcnt"}, 32'(flush_cnt), 32'd0);
    endtask

    initial begin
        idle();
        @(posedge clk);
        #1;
        do_reset("reset");

        // Load-use: single bubble, then clear once the load moves on.
        ex_mem_read = 1'b1; ex_rd_addr = 5'd5; id_rs1_addr = 5'd5; id_rs1_used = 1'b1;
        cyc("lu_stall", C_LU);
        ex_mem_read = 1'b0;
        cyc("lu_after", C_NONE);
        check("lu_scnt", 32'(stall_cnt), 32'd1);

        // No false hazards.
        ex_mem_read = 1'b1; ex_rd_addr = 5'd0; id_rs1_addr = 5'd0; id_rs1_used = 1'b1;
        cyc("x0_nohaz", C_NONE);
        ex_rd_addr = 5'd7; id_rs1_addr = 5'd3; id_rs2_addr = 5'd7; id_rs2_used = 1'b0;
        cyc("rs2_unused", C_NONE);
        id_rs2_used = 1'b1;
        cyc("rs2_lu", C_LU);
        check("rs2_scnt", 32'(stall_cnt), 32'd2);

        // Redirect beats load-use.
        do_reset("rst2");
        ex_mem_read = 1'b1; ex_rd_addr = 5'd5; id_rs1_addr = 5'd5; id_rs1_used = 1'b1;
        ex_redirect = 1'b1;
        cyc("red_lu", C_RED);
        idle();
        cyc("red_after", C_NONE);
        check("red_fcnt", 32'(flush_cnt), 32'd1);
        check("red_scnt", 32'(stall_cnt), 32'd0);

        // Memory wait: 3 frozen cycles then release.
        do_reset("rst3");
        mem_active = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) cyc($sformatf("mw_frz%0d", i), C_FRZ);
        dmem_ready = 1'b1;
        cyc("mw_release", C_NONE);
        check("mw_scnt", 32'(stall_cnt), 32'd3);
        cyc("mw_ready_run", C_NONE);
        // Release cycle resolves a pending load-use immediately.
        dmem_ready = 1'b0;
        cyc("mw2_frz", C_FRZ);
        dmem_ready = 1'b1;
        ex_mem_read = 1'b1; ex_rd_addr = 5'd9; id_rs2_addr = 5'd9; id_rs2_used = 1'b1;
        cyc("mw2_rel_lu", C_LU);

        // Redirect held across a 2-cycle freeze is honoured on release.
        do_reset("rst4");
        mem_active = 1'b1; dmem_ready = 1'b0; ex_redirect = 1'b1;
        cyc("rw_frz0", C_FRZ);
        cyc("rw_frz1", C_FRZ);
        check("rw_fcnt_frozen", 32'(flush_cnt), 32'd0);
        dmem_ready = 1'b1;
        cyc("rw_release", C_RED);
        check("rw_fcnt", 32'(flush_cnt), 32'd1);
        check("rw_scnt", 32'(stall_cnt), 32'd2);

        // Reset aborts a memory wait: pipe runs freely afterwards.
        do_reset("rst5");
        mem_active = 1'b1; dmem_ready = 1'b0;
        cyc("ab_frz0", C_FRZ);
        cyc("ab_frz1", C_FRZ);
        rst = 1'b1;
        cyc("ab_rst", C_RST);
        idle();
        cyc("ab_run", C_NONE);

        // Timeout: 1 RUN + TO wait cycles frozen, then HALT_ERR.
        do_reset("rst6");
        mem_active = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < TO; i++) begin
            cyc($sformatf("to_frz%0d", i), C_FRZ);
            check($sformatf("to_err%0d", i), 32'(err), 32'd0);
        end
        cyc("to_frz_last", C_FRZ);
        check("to_err_set", 32'(err), 32'd1);
        mem_active = 1'b0; dmem_ready = 1'b1; ex_redirect = 1'b1;
        for (int i = 0; i < 12; i++) cyc($sformatf("halt%0d", i), C_FRZ);
        check("halt_err", 32'(err), 32'd1);
        check("halt_fcnt", 32'(flush_cnt), 32'd0);
        check("scnt_sat", 32'(stall_cnt), 32'd15);
        do_reset("rst7");
        cyc("post_halt", C_NONE);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
